seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 150 +++++++++++++++
 tb/tb_seq_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: 6-bit signed truncating divider built on an unsigned restoring core (FSM IDLE/CALC/FIX).
// Latency: start sampled at edge 0 -> done pulse with Q/R after edge 7; start is ignored while busy.
// Option: define DIV_ZERO_DETECT_EN for an early exit on Y=0 (done after edge 1, dbz=1); otherwise dbz is tied 0.
module seq_divider (
  input  logic       clk,
  input  logic       load,
  input  logic       start,
  input  logic [5:0] X,
  input  logic [5:0] Y,
  output logic [5:0] Q,
  output logic [5:0] R,
  output logic       busy,
  output logic       done,
  output logic       dbz
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;     // iteration counter
  logic [5:0] rem_q, rem_d;     // partial remainder (unsigned)
  logic [5:0] dvd_q, dvd_d;     // |X| shifts out MSB first, quotient bits shift in at LSB
  logic [5:0] dvs_q, dvs_d;     // |Y|
  logic       qneg_q, qneg_d;   // quotient sign: X[5]^Y[5]
  logic       xneg_q, xneg_d;   // remainder takes the sign of X
  logic [5:0] q_q, q_d;
  logic [5:0] r_q, r_d;
  logic       done_q, done_d;
  logic       zdiv_q, zdiv_d;   // divide-by-zero captured at start
  logic       early_fix;        // skip CALC for a zero divisor
  logic [6:0] shifted;
  logic       no_borrow;
  logic [5:0] abs_x, abs_y;

  assign abs_x = X[5] ? (~X + 6'd1) : X;
  assign abs_y = Y[5] ? (~Y + 6'd1) : Y;

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q, dbz_d;
  assign early_fix = (Y == 6'd0);
`else
  assign early_fix = 1'b0;
`endif

  // State and datapath registers; load=0 is a synchronous clear that overrides everything
  always_ff @(posedge clk) begin
    if (!load) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rem_q   <= 6'd0;
      dvd_q   <= 6'd0;
      dvs_q   <= 6'd0;
      qneg_q  <= 1'b0;
      xneg_q  <= 1'b0;
      q_q     <= 6'd0;
      r_q     <= 6'd0;
      done_q  <= 1'b0;
      zdiv_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      xneg_q  <= xneg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
      zdiv_q  <= zdiv_d;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  // Next state: IDLE waits for start, CALC runs six iterations, FIX lasts a single edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = early_fix ? FIX : CALC;
      CALC:    if (cnt_q == 3'd5) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture operands in IDLE, one restoring step per CALC edge, sign-correct in FIX
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    xneg_d    = xneg_q;
    q_d       = q_q;
    r_d       = r_q;
    done_d    = 1'b0;
    zdiv_d    = zdiv_q;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d     = dbz_q;
`endif
    shifted   = {rem_q, dvd_q[5]};
    no_borrow = (shifted >= {1'b0, dvs_q});
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d  = 3'd0;
          rem_d  = early_fix ? abs_x : 6'd0;  // early exit needs |X| as the remainder
          dvd_d  = abs_x;
          dvs_d  = abs_y;
          qneg_d = X[5] ^ Y[5];
          xneg_d = X[5];
          zdiv_d = early_fix;
        end
      end
      CALC: begin
        rem_d = no_borrow ? 6'(shifted - {1'b0, dvs_q}) : shifted[5:0];
        dvd_d = {dvd_q[4:0], no_borrow};
        cnt_d = cnt_q + 3'd1;
      end
      FIX: begin
        q_d    = zdiv_q ? 6'b111111 : (qneg_q ? (~dvd_q + 6'd1) : dvd_q);
        r_d    = xneg_q ? (~rem_q + 6'd1) : rem_q;
        done_d = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
        dbz_d  = zdiv_q;
`endif
      end
      default: ;
    endcase
  end

  // Outputs: registered results, busy decoded from the state register
  always_comb begin
    Q    = q_q;
    R    = r_q;
    done = done_q;
    busy = (state_q != IDLE);
`ifdef DIV_ZERO_DETECT_EN
    dbz  = dbz_q;
`else
    dbz  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: vector table, hand-written multi-cycle sequences, random operands vs arithmetic model.
module tb_seq_divider;
  logic       clk = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic [5:0] X = 6'd0;
  logic [5:0] Y = 6'd0;
  logic [5:0] Q, R;
  logic       busy, done, dbz;
  int n_chk = 0;
  int n_fail = 0;

`ifdef DIV_ZERO_DETECT_EN
  localparam int ZLAT = 1;
  localparam int ZDBZ = 1;
`else
  localparam int ZLAT = 7;
  localparam int ZDBZ = 0;
`endif

  seq_divider dut (.clk(clk), .load(load), .start(start), .X(X), .Y(Y),
                   .Q(Q), .R(R), .busy(busy), .done(done), .dbz(dbz));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer division (truncating), with the zero-divisor conventions
  function automatic void ref_div(input logic [5:0] x, input logic [5:0] y,
                                  output logic [5:0] q, output logic [5:0] r);
    int xi, yi, qi, ri;
    xi = int'($signed(x));
    yi = int'($signed(y));
    if (yi == 0) begin
`ifdef DIV_ZERO_DETECT_EN
      qi = -1;
`else
      qi = (xi >= 0) ? -1 : 1;
`endif
      ri = xi;
    end else begin
      qi = xi / yi;
      ri = xi % yi;
    end
    q = qi[5:0];
    r = ri[5:0];
  endfunction

  // Issue one division from idle, scramble X/Y while busy, and check latency and results
  task automatic do_div(input logic [5:0] x, input logic [5:0] y, input logic [5:0] eq,
                        input logic [5:0] er, input int edbz, input int elat, input string nm);
    int cyc;
    X = x; Y = y; start = 1'b1;
    tick();
    start = 1'b0;
    X = 6'($urandom); Y = 6'($urandom);
    chk({nm, " busy_after_start"}, int'(busy), 1);
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({nm, " latency"}, cyc, elat);
    chk({nm, " Q"}, int'($signed(Q)), int'($signed(eq)));
    chk({nm, " R"}, int'($signed(R)), int'($signed(er)));
    chk({nm, " dbz"}, int'(dbz), edbz);
    chk({nm, " busy_at_done"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [5:0] x;
    logic [5:0] y;
    logic [5:0] q;
    logic [5:0] r;
    string      nm;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [5:0] eq, er, rx, ry;
    int cyc, ndone;

    tbl[0] = '{6'd13,      6'd4,      6'd3,       6'd1,       "13/4"};
    tbl[1] = '{6'(-13),    6'd4,      6'(-3),     6'(-1),     "-13/4"};
    tbl[2] = '{6'd13,      6'(-4),    6'(-3),     6'd1,       "13/-4"};
    tbl[3] = '{6'(-13),    6'(-4),    6'd3,       6'(-1),     "-13/-4"};
    tbl[4] = '{6'(-32),    6'(-1),    6'(-32),    6'd0,       "-32/-1"};
    tbl[5] = '{6'(-32),    6'd1,      6'(-32),    6'd0,       "-32/1"};
    tbl[6] = '{6'd31,      6'd31,     6'd1,       6'd0,       "31/31"};

    // Reset held for two edges
    load = 1'b0;
    tick(); tick();
    load = 1'b1;
    chk("reset Q", int'(Q), 0);
    chk("reset R", int'(R), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset dbz", int'(dbz), 0);

    foreach (tbl[i]) do_div(tbl[i].x, tbl[i].y, tbl[i].q, tbl[i].r, 0, 7, tbl[i].nm);

    // Zero divisor, positive and negative dividend
    do_div(6'd7, 6'd0, 6'(-1), 6'd7, ZDBZ, ZLAT, "7/0");
    ref_div(6'(-5), 6'd0, eq, er);
    do_div(6'(-5), 6'd0, eq, er, ZDBZ, ZLAT, "-5/0");

    // Start during busy is ignored; start in the done cycle is accepted
    X = 6'd20; Y = 6'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    X = 6'd5; Y = 6'd1; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 3;
    while (!done && cyc < 20) begin tick(); cyc++; end
    chk("ignored_start latency", cyc, 7);
    chk("ignored_start Q", int'($signed(Q)), 6);
    chk("ignored_start R", int'($signed(R)), 2);
    X = 6'd5; Y = 6'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b busy", int'(busy), 1);
    chk("b2b Q_hold", int'($signed(Q)), 6);
    chk("b2b done_cleared", int'(done), 0);
    cyc = 0;
    while (!done && cyc < 20) begin tick(); cyc++; end
    chk("b2b latency", cyc, 7);
    chk("b2b Q", int'($signed(Q)), 5);
    chk("b2b R", int'($signed(R)), 0);

    // Abort mid-operation
    X = 6'd20; Y = 6'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    load = 1'b0;
    tick();
    chk("abort Q", int'(Q), 0);
    chk("abort R", int'(R), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    load = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort no_done", ndone, 0);

    // Reset wins over start in the same cycle
    X = 6'd9; Y = 6'd2; load = 1'b0; start = 1'b1;
    tick();
    load = 1'b1; start = 1'b0;
    chk("reset_priority busy", int'(busy), 0);
    tick();
    chk("reset_priority busy2", int'(busy), 0);

    // Random operands against the arithmetic model and the X = Q*Y + R identity
    for (int n = 0; n < 150; n++) begin
      rx = 6'($urandom);
      ry = 6'($urandom);
      if (ry == 6'd0) ry = 6'd1;
      if (rx == 6'b100000 && ry == 6'b111111) ry = 6'd3;
      ref_div(rx, ry, eq, er);
      do_div(rx, ry, eq, er, 0, 7, $sformatf("rand%0d", n));
      chk($sformatf("rand%0d identity", n),
          int'($signed(Q)) * int'($signed(ry)) + int'($signed(R)), int'($signed(rx)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
